// File: rtl/adc_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_scheduler
// Description : Shares one SPI ADC conversion engine between periodic
//               round-robin channel scans and on-demand single conversions.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int CH_W     = 3,
    parameter int SCAN_DIV = 50000,
    parameter int TIMEOUT  = 2047
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scan_en,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic                od_req,
    input  logic [CH_W-1:0]     od_ch,
    output logic                od_ack,
    output logic [7:0]          od_data,
    output logic                od_err,
    output logic                conv_start,
    output logic [CH_W-1:0]     conv_ch,
    input  logic                conv_done,
    input  logic [7:0]          conv_data,
    output logic [8*NUM_CH-1:0] ch_data,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                scan_done,
    output logic                timeout_err
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                pending_q, pending_d;
    logic                active_q, active_d;
    logic                job_od_q, job_od_d;
    logic [CH_W-1:0]     scan_ch_q, scan_ch_d;
    logic                conv_start_q, conv_start_d;
    logic [CH_W-1:0]     conv_ch_q, conv_ch_d;
    logic                od_ack_q, od_ack_d;
    logic [7:0]          od_data_q, od_data_d;
    logic                od_err_q, od_err_d;
    logic [8*NUM_CH-1:0] ch_data_q, ch_data_d;
    logic [NUM_CH-1:0]   ch_valid_q, ch_valid_d;
    logic                scan_done_q, scan_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic                first_vld, next_vld;
    logic [CH_W-1:0]     first_ch, next_ch;
    logic                tick_wrap;
    logic                store_now, store_err;

    // Lowest enabled channel overall, and lowest enabled channel above the
    // last scanned one; the descending loop lets the lowest index win.
    always_comb begin
        first_vld = 1'b0;
        first_ch  = '0;
        next_vld  = 1'b0;
        next_ch   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_vld = 1'b1;
                first_ch  = CH_W'(k);
                if (k > int'(scan_ch_q)) begin
                    next_vld = 1'b1;
                    next_ch  = CH_W'(k);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        tmo_d         = tmo_q;
        pending_d     = pending_q;
        active_d      = active_q;
        job_od_d      = job_od_q;
        scan_ch_d     = scan_ch_q;
        conv_start_d  = 1'b0;
        conv_ch_d     = conv_ch_q;
        od_ack_d      = 1'b0;
        od_data_d     = od_data_q;
        od_err_d      = od_err_q;
        ch_data_d     = ch_data_q;
        ch_valid_d    = ch_valid_q;
        scan_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        tick_wrap     = 1'b0;
        store_now     = 1'b0;
        store_err     = 1'b0;

        if (scan_en) begin
            if (tick_q == TICK_LAST) begin
                tick_d    = '0;
                tick_wrap = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end else begin
            tick_d    = '0;
            pending_d = 1'b0;
            active_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (od_req) begin
                    job_od_d     = 1'b1;
                    conv_ch_d    = od_ch;
                    conv_start_d = 1'b1;
                    tmo_d        = '0;
                    state_d      = S_ISSUE;
                end else if (active_q && scan_en) begin
                    if (next_vld) begin
                        job_od_d     = 1'b0;
                        conv_ch_d    = next_ch;
                        scan_ch_d    = next_ch;
                        conv_start_d = 1'b1;
                        tmo_d        = '0;
                        state_d      = S_ISSUE;
                    end else begin
                        // Mask shrank under an interleaved on-demand job.
                        active_d = 1'b0;
                    end
                end else if (pending_q && scan_en) begin
                    pending_d = 1'b0;
                    if (first_vld) begin
                        active_d     = 1'b1;
                        job_od_d     = 1'b0;
                        conv_ch_d    = first_ch;
                        scan_ch_d    = first_ch;
                        conv_start_d = 1'b1;
                        tmo_d        = '0;
                        state_d      = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done) begin
                    store_now = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    store_now     = 1'b1;
                    store_err     = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_STORE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are registered on entry to S_STORE so they are visible
        // during the store cycle itself.
        if (store_now) begin
            state_d = S_STORE;
            if (job_od_q) begin
                od_ack_d  = 1'b1;
                od_err_d  = store_err;
                od_data_d = store_err ? 8'h00 : conv_data;
            end else begin
                if (store_err) begin
                    ch_valid_d[conv_ch_q] = 1'b0;
                end else begin
                    ch_data_d[8*int'(conv_ch_q) +: 8] = conv_data;
                    ch_valid_d[conv_ch_q]             = 1'b1;
                end
                if (active_q && scan_en && !next_vld) begin
                    scan_done_d = 1'b1;
                    active_d    = 1'b0;
                end
            end
        end

        if (tick_wrap) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            tmo_q         <= '0;
            pending_q     <= 1'b0;
            active_q      <= 1'b0;
            job_od_q      <= 1'b0;
            scan_ch_q     <= '0;
            conv_start_q  <= 1'b0;
            conv_ch_q     <= '0;
            od_ack_q      <= 1'b0;
            od_data_q     <= '0;
            od_err_q      <= 1'b0;
            ch_data_q     <= '0;
            ch_valid_q    <= '0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            tmo_q         <= tmo_d;
            pending_q     <= pending_d;
            active_q      <= active_d;
            job_od_q      <= job_od_d;
            scan_ch_q     <= scan_ch_d;
            conv_start_q  <= conv_start_d;
            conv_ch_q     <= conv_ch_d;
            od_ack_q      <= od_ack_d;
            od_data_q     <= od_data_d;
            od_err_q      <= od_err_d;
            ch_data_q     <= ch_data_d;
            ch_valid_q    <= ch_valid_d;
            scan_done_q   <= scan_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign conv_start  = conv_start_q;
    assign conv_ch     = conv_ch_q;
    assign od_ack      = od_ack_q;
    assign od_data     = od_data_q;
    assign od_err      = od_err_q;
    assign ch_data     = ch_data_q;
    assign ch_valid    = ch_valid_q;
    assign scan_done   = scan_done_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
